// File: rtl/gfx_wbm_pkg.sv
// Shared encodings for the graphics Wishbone master arbiter.
// Requester indices, arbiter states and the default grant timeout.
package gfx_wbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    localparam logic [1:0] REQ_M0 = 2'd0;
    localparam logic [1:0] REQ_M1 = 2'd1;
    localparam logic [1:0] REQ_M2 = 2'd2;
    localparam logic [1:0] REQ_MW = 2'd3;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/gfx_rr_pick.sv
// 4-way rotate-priority pick: first requester after 'last',
// wrapping around so 'last' itself is searched at the end.
module gfx_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gfx_wbm_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone master between
// the clip, fragment and blender readers and the writer.
module gfx_wbm_rr_arbiter
    import gfx_wbm_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        master_busy_o,
    output logic        read_request_o,
    output logic        write_request_o,
    output logic [31:2] addr_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic        mw_write_request_i,
    input  logic [31:2] mw_addr_i,
    input  logic [3:0]  mw_sel_i,
    input  logic        mw_we_i,
    input  logic [31:0] mw_dat_i,
    output logic        mw_ack_o,
    input  logic        m0_read_request_i,
    input  logic [31:2] m0_addr_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_read_request_i,
    input  logic [31:2] m1_addr_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    input  logic        m2_read_request_i,
    input  logic [31:2] m2_addr_i,
    input  logic [3:0]  m2_sel_i,
    output logic [31:0] m2_dat_o,
    output logic        m2_ack_o,
    output logic        timeout_o
);

    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  req_vec;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        in_grant;
    logic        ack_gate;

    assign req_vec = {mw_write_request_i, m2_read_request_i,
                      m1_read_request_i, m0_read_request_i};

    gfx_rr_pick u_pick (
        .req   (req_vec),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= REQ_M0;
            last_q    <= REQ_MW;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Ack beats both a dropped request and counter expiry.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (ack_i) begin
                    state_d = ST_GAP;
                end else if (!req_vec[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_grant = (state_q == ST_GRANT);
    // A stray ack in the reset cycle must not complete the transfer.
    assign ack_gate = ack_i & in_grant & ~rst_i;

    always_comb begin
        addr_o = '0;
        sel_o  = '0;
        we_o   = 1'b0;
        if (in_grant) begin
            case (grant_q)
                REQ_M0: begin
                    addr_o = m0_addr_i;
                    sel_o  = m0_sel_i;
                end
                REQ_M1: begin
                    addr_o = m1_addr_i;
                    sel_o  = m1_sel_i;
                end
                REQ_M2: begin
                    addr_o = m2_addr_i;
                    sel_o  = m2_sel_i;
                end
                default: begin
                    addr_o = mw_addr_i;
                    sel_o  = mw_sel_i;
                    we_o   = mw_we_i;
                end
            endcase
        end
    end

    assign master_busy_o   = |req_vec;
    assign read_request_o  = in_grant & (grant_q != REQ_MW);
    assign write_request_o = in_grant & (grant_q == REQ_MW);
    assign timeout_o       = timeout_q;

    assign m0_ack_o = ack_gate & (grant_q == REQ_M0);
    assign m1_ack_o = ack_gate & (grant_q == REQ_M1);
    assign m2_ack_o = ack_gate & (grant_q == REQ_M2);
    assign mw_ack_o = ack_gate & (grant_q == REQ_MW);

    assign dat_o    = mw_dat_i;
    assign m0_dat_o = dat_i;
    assign m1_dat_o = dat_i;
    assign m2_dat_o = dat_i;

endmodule

// File: tb/tb_gfx_wbm_rr_arbiter.sv
// Directed bench for gfx_wbm_rr_arbiter with TIMEOUT=4.
module tb_gfx_wbm_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        master_busy_o;
    logic        read_request_o;
    logic        write_request_o;
    logic [31:2] addr_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_i;
    logic        mw_write_request_i;
    logic [31:2] mw_addr_i;
    logic [3:0]  mw_sel_i;
    logic        mw_we_i;
    logic [31:0] mw_dat_i;
    logic        mw_ack_o;
    logic        m0_read_request_i;
    logic [31:2] m0_addr_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic        m1_read_request_i;
    logic [31:2] m1_addr_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic        m2_read_request_i;
    logic [31:2] m2_addr_i;
    logic [3:0]  m2_sel_i;
    logic [31:0] m2_dat_o;
    logic        m2_ack_o;
    logic        timeout_o;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] acks;
    assign acks = {mw_ack_o, m2_ack_o, m1_ack_o, m0_ack_o};

    always #5 clk_i = ~clk_i;

    gfx_wbm_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .master_busy_o      (master_busy_o),
        .read_request_o     (read_request_o),
        .write_request_o    (write_request_o),
        .addr_o             (addr_o),
        .sel_o              (sel_o),
        .we_o               (we_o),
        .dat_i              (dat_i),
        .dat_o              (dat_o),
        .ack_i              (ack_i),
        .mw_write_request_i (mw_write_request_i),
        .mw_addr_i          (mw_addr_i),
        .mw_sel_i           (mw_sel_i),
        .mw_we_i            (mw_we_i),
        .mw_dat_i           (mw_dat_i),
        .mw_ack_o           (mw_ack_o),
        .m0_read_request_i  (m0_read_request_i),
        .m0_addr_i          (m0_addr_i),
        .m0_sel_i           (m0_sel_i),
        .m0_dat_o           (m0_dat_o),
        .m0_ack_o           (m0_ack_o),
        .m1_read_request_i  (m1_read_request_i),
        .m1_addr_i          (m1_addr_i),
        .m1_sel_i           (m1_sel_i),
        .m1_dat_o           (m1_dat_o),
        .m1_ack_o           (m1_ack_o),
        .m2_read_request_i  (m2_read_request_i),
        .m2_addr_i          (m2_addr_i),
        .m2_sel_i           (m2_sel_i),
        .m2_dat_o           (m2_dat_o),
        .m2_ack_o           (m2_ack_o),
        .timeout_o          (timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reqs(input logic [3:0] r);
        m0_read_request_i  = r[0];
        m1_read_request_i  = r[1];
        m2_read_request_i  = r[2];
        mw_write_request_i = r[3];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_idx;
        rst_i     = 1'b1;
        ack_i     = 1'b0;
        dat_i     = 32'h0;
        mw_addr_i = 30'h0003_0000;
        mw_sel_i  = 4'h3;
        mw_we_i   = 1'b1;
        mw_dat_i  = 32'hCAFE_F00D;
        m0_addr_i = 30'h0000_0100;
        m0_sel_i  = 4'h1;
        m1_addr_i = 30'h0000_0200;
        m1_sel_i  = 4'h2;
        m2_addr_i = 30'h0000_0300;
        m2_sel_i  = 4'h4;
        set_reqs(4'b0000);
        tick();
        tick();
        chk("rst_rd", 32'(read_request_o), 32'd0);
        chk("rst_wr", 32'(write_request_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_to", 32'(timeout_o), 32'd0);
        chk("rst_busy", 32'(master_busy_o), 32'd0);
        rst_i = 1'b0;

        // m0 and mw request together: m0 first, then mw
        set_reqs(4'b1001);
        #1;
        chk("t1_busy", 32'(master_busy_o), 32'd1);
        chk("t1_idle_rd", 32'(read_request_o), 32'd0);
        tick();
        chk("t1_g0_rd", 32'(read_request_o), 32'd1);
        chk("t1_g0_wr", 32'(write_request_o), 32'd0);
        chk("t1_g0_addr", 32'(addr_o), 32'h0000_0100);
        chk("t1_g0_we", 32'(we_o), 32'd0);
        tick();
        ack_i = 1'b1;
        #1;
        chk("t1_g0_ack", 32'(acks), 32'b0001);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b1000);
        chk("t1_gap_rd", 32'(read_request_o), 32'd0);
        chk("t1_gap_wr", 32'(write_request_o), 32'd0);
        tick();
        chk("t1_idle_wr", 32'(write_request_o), 32'd0);
        tick();
        chk("t1_gw_wr", 32'(write_request_o), 32'd1);
        chk("t1_gw_rd", 32'(read_request_o), 32'd0);
        chk("t1_gw_addr", 32'(addr_o), 32'h0003_0000);
        chk("t1_gw_sel", 32'(sel_o), 32'h3);
        chk("t1_gw_we", 32'(we_o), 32'd1);
        chk("t1_dat_o", dat_o, 32'hCAFE_F00D);
        tick();
        ack_i = 1'b1;
        #1;
        chk("t1_gw_ack", 32'(acks), 32'b1000);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b0000);
        chk("t1_gap2_wr", 32'(write_request_o), 32'd0);
        tick();

        // all four request continuously: 0,1,2,3,0,1,2,3
        set_reqs(4'b1111);
        for (int k = 0; k < 8; k++) begin
            exp_idx = 2'(k);
            tick();
            ack_i = 1'b1;
            #1;
            chk("t2_ack", 32'(acks), 32'(4'b0001 << exp_idx));
            chk("t2_wr", 32'(write_request_o), 32'(exp_idx == 2'd3));
            tick();
            ack_i = 1'b0;
            chk("t2_gap_ack", 32'(acks), 32'd0);
            tick();
        end

        // m1 read with data return
        set_reqs(4'b0010);
        m1_addr_i = 30'h0000_1000;
        m1_sel_i  = 4'hF;
        tick();
        chk("t3_addr", 32'(addr_o), 32'h0000_1000);
        chk("t3_sel", 32'(sel_o), 32'hF);
        chk("t3_we", 32'(we_o), 32'd0);
        ack_i = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        #1;
        chk("t3_acks", 32'(acks), 32'b0010);
        chk("t3_dat", m1_dat_o, 32'hDEAD_BEEF);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b0000);
        chk("t3_gap_addr", 32'(addr_o), 32'd0);
        tick();

        // m2 with no ack: timeout after 4 grant cycles
        set_reqs(4'b0100);
        tick();
        chk("t4_rd", 32'(read_request_o), 32'd1);
        tick();
        tick();
        tick();
        chk("t4_last_g_rd", 32'(read_request_o), 32'd1);
        chk("t4_last_g_to", 32'(timeout_o), 32'd0);
        tick();
        chk("t4_gap_to", 32'(timeout_o), 32'd1);
        chk("t4_gap_rd", 32'(read_request_o), 32'd0);
        chk("t4_gap_ack", 32'(acks), 32'd0);
        tick();
        chk("t4_idle_to", 32'(timeout_o), 32'd0);
        chk("t4_idle_rd", 32'(read_request_o), 32'd0);
        tick();
        chk("t4_regrant", 32'(addr_o), 32'h0000_0300);
        tick();
        tick();
        tick();
        ack_i = 1'b1;
        #1;
        chk("t5_exp_ack", 32'(acks), 32'b0100);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b0000);
        chk("t5_exp_to", 32'(timeout_o), 32'd0);
        tick();

        // requester drops mid-grant: straight back to idle
        set_reqs(4'b0001);
        tick();
        chk("t6_rd", 32'(read_request_o), 32'd1);
        set_reqs(4'b0000);
        #1;
        chk("t6_drop_ack", 32'(acks), 32'd0);
        tick();
        chk("t6_idle_rd", 32'(read_request_o), 32'd0);
        chk("t6_idle_to", 32'(timeout_o), 32'd0);
        set_reqs(4'b0010);
        tick();
        chk("t6_next_addr", 32'(addr_o), 32'h0000_1000);
        ack_i = 1'b1;
        #1;
        chk("t6_next_ack", 32'(acks), 32'b0010);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b0000);
        tick();

        // reset while granted, stray ack ignored
        set_reqs(4'b1111);
        tick();
        chk("t7_g_addr", 32'(addr_o), 32'h0000_0300);
        rst_i = 1'b1;
        ack_i = 1'b1;
        #1;
        chk("t7_rst_ack", 32'(acks), 32'd0);
        tick();
        chk("t7_post_rd", 32'(read_request_o), 32'd0);
        chk("t7_post_addr", 32'(addr_o), 32'd0);
        chk("t7_post_sel", 32'(sel_o), 32'd0);
        chk("t7_post_ack", 32'(acks), 32'd0);
        rst_i = 1'b0;
        ack_i = 1'b0;
        tick();
        ack_i = 1'b1;
        #1;
        chk("t7_first_m0", 32'(acks), 32'b0001);
        tick();
        ack_i = 1'b0;
        set_reqs(4'b0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
